// File: rtl/alu_md_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_md_exec
//  Purpose  : Execute-stage ALU-control decode plus iterative MUL/DIV sequencer.
//             Divider datapath is built only when ALU_MD_DIV_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module alu_md_exec #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      func73_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            illegal_o
);

    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
        OP_SLTU, OP_MUL, OP_MULH, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t            r_state, w_state_n;
    op_t               w_op, r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_acc, r_lo, r_b;
    logic              r_neg_a, r_neg_b;
    logic [XLEN-1:0]   w_alu, w_final, w_acc_n, w_lo_n, w_addend;
    logic [XLEN:0]     w_msum;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [SH_W-1:0]   w_sh;
    logic              w_is_mul, w_is_div, w_sgn, w_accept, w_last;
`ifdef ALU_MD_DIV_EN
    logic              r_div0;
    logic [XLEN:0]     w_t;
    logic [XLEN-1:0]   w_diff, w_rem, w_quo;
    logic              w_ge;
`endif

    always_comb begin
        w_op = OP_ILL;
        case (ALUOp_i)
            2'b00: w_op = OP_ADD;
            2'b10: begin
                case (func73_i)
                    10'b0000000_000: w_op = OP_ADD;
                    10'b0100000_000: w_op = OP_SUB;
                    10'b0000000_001: w_op = OP_SLL;
                    10'b0000000_010: w_op = OP_SLT;
                    10'b0000000_011: w_op = OP_SLTU;
                    10'b0000000_100: w_op = OP_XOR;
                    10'b0000000_101: w_op = OP_SRL;
                    10'b0000000_110: w_op = OP_OR;
                    10'b0000000_111: w_op = OP_AND;
                    10'b0000001_000: w_op = OP_MUL;
                    10'b0000001_001: w_op = OP_MULH;
`ifdef ALU_MD_DIV_EN
                    10'b0000001_100: w_op = OP_DIV;
                    10'b0000001_101: w_op = OP_DIVU;
                    10'b0000001_110: w_op = OP_REM;
                    10'b0000001_111: w_op = OP_REMU;
`endif
                    default:         w_op = OP_ILL;
                endcase
            end
            2'b11: begin
                if (func73_i[2:0] == 3'b000)
                    w_op = OP_ADD;
                else if (func73_i == 10'b0100000_101)
                    w_op = OP_SRA;
            end
            default: w_op = OP_ILL;
        endcase
    end

    assign w_is_mul = (w_op == OP_MUL) || (w_op == OP_MULH);
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU) || (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_sgn    = w_is_mul || (w_op == OP_DIV) || (w_op == OP_REM);
    assign busy_o   = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_accept = start_i && !flush_i && !busy_o;
    assign w_last   = (r_cnt == CNT_W'(XLEN));
    assign w_sh     = rs2_i[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = rs1_i + rs2_i;
            OP_SUB:  w_alu = rs1_i - rs2_i;
            OP_AND:  w_alu = rs1_i & rs2_i;
            OP_OR:   w_alu = rs1_i | rs2_i;
            OP_XOR:  w_alu = rs1_i ^ rs2_i;
            OP_SLL:  w_alu = rs1_i << w_sh;
            OP_SRL:  w_alu = rs1_i >> w_sh;
            OP_SRA:  w_alu = $signed(rs1_i) >>> w_sh;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_i) < $signed(rs2_i)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, rs1_i < rs2_i};
            default: w_alu = '0;
        endcase
    end

    // One iteration step; on the final count the sign-corrected result is formed too.
    always_comb begin
        w_addend   = r_lo[0] ? r_b : '0;
        w_msum     = {1'b0, r_acc} + {1'b0, w_addend};
        w_acc_n    = w_msum[XLEN:1];
        w_lo_n     = {w_msum[0], r_lo[XLEN-1:1]};
        w_prod     = {w_acc_n, w_lo_n};
        w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
        w_final    = '0;
        case (r_op)
            OP_MUL:  w_final = w_prod_fix[XLEN-1:0];
            OP_MULH: w_final = w_prod_fix[2*XLEN-1:XLEN];
            default: w_final = '0;
        endcase
`ifdef ALU_MD_DIV_EN
        w_t    = {r_acc, r_lo[XLEN-1]};
        w_ge   = w_t >= {1'b0, r_b};
        w_diff = w_t[XLEN-1:0] - r_b;
        w_rem  = w_ge ? w_diff : w_t[XLEN-1:0];
        w_quo  = {r_lo[XLEN-2:0], w_ge};
        if (r_state == ST_DIV) begin
            w_acc_n = w_rem;
            w_lo_n  = w_quo;
            case (r_op)
                OP_DIV, OP_DIVU: w_final = r_div0 ? '1 : ((r_neg_a ^ r_neg_b) ? -w_quo : w_quo);
                OP_REM, OP_REMU: w_final = r_neg_a ? -w_rem : w_rem;
                default:         w_final = '0;
            endcase
        end
`endif
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_n = ST_IDLE;
                if (w_accept && w_is_mul)
                    w_state_n = ST_MUL;
                else if (w_accept && w_is_div)
                    w_state_n = ST_DIV;
            end
            ST_MUL, ST_DIV: if (w_last) w_state_n = ST_DONE;
            default: w_state_n = ST_IDLE;
        endcase
        if (flush_i)
            w_state_n = ST_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o  <= '0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
`ifdef ALU_MD_DIV_EN
            r_div0    <= 1'b0;
`endif
        end else begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            if (w_accept) begin
                if (w_is_mul || w_is_div) begin
                    r_op    <= w_op;
                    r_lo    <= rs1_i;
                    r_b     <= rs2_i;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_neg_a <= w_sgn & rs1_i[XLEN-1];
                    r_neg_b <= w_sgn & rs2_i[XLEN-1];
`ifdef ALU_MD_DIV_EN
                    r_div0  <= (rs2_i == '0);
`endif
                end else begin
                    result_o  <= w_alu;
                    valid_o   <= 1'b1;
                    illegal_o <= (w_op == OP_ILL);
                end
            end else if (busy_o && !flush_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // First busy cycle converts latched operands to magnitudes.
                if (r_cnt == '0) begin
                    r_lo <= r_neg_a ? -r_lo : r_lo;
                    r_b  <= r_neg_b ? -r_b : r_b;
                end else begin
                    r_acc <= w_acc_n;
                    r_lo  <= w_lo_n;
                    if (w_last) begin
                        result_o <= w_final;
                        valid_o  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_md_exec
//  Purpose  : Randomized self-checking bench for alu_md_exec against an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_md_exec;

    localparam int XLEN = 32;
`ifdef ALU_MD_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [1:0]      aluop;
    logic [9:0]      f73;
    logic [XLEN-1:0] rs1, rs2, result;
    logic            valid, busy, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_md_exec #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
        .ALUOp_i(aluop), .func73_i(f73), .rs1_i(rs1), .rs2_i(rs2),
        .result_o(result), .valid_o(valid), .busy_o(busy), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] aop, input logic [9:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output bit multi);
        longint p;
        int     ia, ib;
        logic [4:0] sh;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ovf;
        ia = a; ib = b; sh = b[4:0]; f3 = f[2:0]; f7 = f[9:3];
        p   = longint'(ia) * longint'(ib);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = '0; ill = 1'b0; multi = 1'b0;
        if (aop == 2'b00)
            r = a + b;
        else if (aop == 2'b11) begin
            if (f3 == 3'b000) r = a + b;
            else if (f == 10'b0100000_101) r = ia >>> sh;
            else ill = 1'b1;
        end else if (aop == 2'b01)
            ill = 1'b1;
        else if (f7 == 7'b0000000) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << sh;
                3'd2: r = (ia < ib) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000)
            r = a - b;
        else if (f7 == 7'b0000001) begin
            if (f3 == 3'd0) begin r = p[31:0]; multi = 1'b1; end
            else if (f3 == 3'd1) begin r = p[63:32]; multi = 1'b1; end
            else if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            else if (!DIV_ON) ill = 1'b1;
            else begin
                multi = 1'b1;
                case (f3)
                    3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : ia / ib);
                    3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                    3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : ia % ib);
                    default: r = (b == 0) ? a : a % b;
                endcase
            end
        end else
            ill = 1'b1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [9:0] f,
                          input logic [31:0] a, input logic [31:0] b, input bit b2b);
        logic [31:0] er;
        bit eill, emul;
        int cyc, bcnt;
        model(aop, f, a, b, er, eill, emul);
        if (!b2b) @(negedge clk);
        aluop = aop; f73 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs1 = $urandom; rs2 = $urandom;
        cyc = 1; bcnt = 0;
        while (!valid && cyc < 100) begin
            if (busy) bcnt++;
            // Stray issues while busy must be ignored.
            start = busy && ($urandom % 4 == 0);
            aluop = 2'($urandom); f73 = 10'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(cyc), emul ? 64'(XLEN + 2) : 64'd1);
        if (emul) chk({tag, "_busycyc"}, 64'(bcnt), 64'(XLEN + 1));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_ill"}, 64'(illegal), 64'(eill));
        chk({tag, "_busydn"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] enc_r [17];
        logic [1:0] aop;
        logic [9:0] f;
        int nv, sel;
        enc_r = '{10'b0000000_111, 10'b0000000_110, 10'b0000000_100, 10'b0000000_001,
                  10'b0000000_101, 10'b0000000_000, 10'b0100000_000, 10'b0000000_010,
                  10'b0000000_011, 10'b0000001_000, 10'b0000001_001, 10'b0000001_010,
                  10'b0000001_100, 10'b0000001_101, 10'b0000001_110, 10'b0000001_111,
                  10'b0000001_011};
        rst = 1'b1; start = 1'b0; flush = 1'b0; aluop = '0; f73 = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ill", 64'(illegal), 64'd0);
        rst = 1'b0;

        run_op("add",    2'b10, 10'b0000000_000, 32'd5, 32'd7, 1'b0);
        run_op("srai",   2'b11, 10'b0100000_101, 32'h8000_0000, 32'd4, 1'b0);
        run_op("mul",    2'b10, 10'b0000001_000, 32'hFFFF_FFFF, 32'd3, 1'b0);
        run_op("mulh",   2'b10, 10'b0000001_001, 32'hFFFF_FFFF, 32'd3, 1'b1);
        run_op("div",    2'b10, 10'b0000001_100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem",    2'b10, 10'b0000001_110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu0",  2'b10, 10'b0000001_101, 32'd1234, 32'd0, 1'b0);
        run_op("removf", 2'b10, 10'b0000001_110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divovf", 2'b10, 10'b0000001_100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("illeg",  2'b10, 10'b1111111_000, 32'd9, 32'd9, 1'b0);
        run_op("addb2b", 2'b00, 10'b1010101_010, 32'd40, 32'd2, 1'b1);

        // Flush mid-operation, with a simultaneous issue that must be dropped.
        @(negedge clk);
        aluop = 2'b10; f73 = DIV_ON ? 10'b0000001_100 : 10'b0000001_000;
        rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("fl_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1; start = 1'b1; aluop = 2'b00; rs1 = 32'd1; rs2 = 32'd1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_valid", 64'(valid), 64'd0);
        nv = 0;
        repeat (40) begin @(negedge clk); if (valid) nv++; end
        chk("fl_novalid", 64'(nv), 64'd0);

        // Reset mid-operation after a known non-zero result.
        run_op("add2", 2'b10, 10'b0000000_000, 32'd5, 32'd7, 1'b0);
        aluop = 2'b10; f73 = 10'b0000001_000; rs1 = 32'd77; rs2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_res", 64'(result), 64'd0);
        chk("mr_valid", 64'(valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_ill", 64'(illegal), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (40) begin @(negedge clk); if (valid || busy) nv++; end
        chk("mr_quiet", 64'(nv), 64'd0);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom % 20;
            if (sel < 17) begin aop = 2'b10; f = enc_r[sel]; end
            else if (sel == 17) begin aop = 2'b11; f = {7'($urandom), 3'b000}; end
            else if (sel == 18) begin aop = 2'b11; f = 10'b0100000_101; end
            else begin aop = 2'($urandom); f = 10'($urandom); end
            run_op("rnd", aop, f, rnd_opnd(), rnd_opnd(), ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_md_exec.md
Name: alu_md_exec

Overview:
- Parametrised execute-stage unit that merges ALU-control decode with an iterative multiply/divide sequencer.
- Decodes ALUOp/funct7/funct3, computes single-cycle ALU ops, and runs multi-cycle MUL/DIV/REM.
- Raises busy_o so the hazard unit stalls IF/ID/EX while an iterative op is in flight.
- Sits between ID/EX and EX/MEM; result_o/valid_o feed the EX/MEM latch.

Parameters:
- XLEN, 32, datapath width; must be a power of two, 8 to 64.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  issue strobe: operands and op valid this cycle.
- flush_i  in  1  abort current op (branch flush); has priority over start_i.
- ALUOp_i  in  2  main-decoder class: 00 add, 10 R-type, 11 I-type.
- func73_i  in  10  {funct7, funct3}.
- rs1_i  in  XLEN  operand A.
- rs2_i  in  XLEN  operand B (or immediate).
- result_o  out  XLEN  registered result.
- valid_o  out  1  one-cycle pulse: result_o valid.
- busy_o  out  1  iterative op in progress; start_i ignored while high.
- illegal_o  out  1  pulse with valid_o when the encoding is not decoded.

Behaviour:
- Reset (async, rst_i=1): state IDLE; result_o=0; valid_o=0; busy_o=0; illegal_o=0; counter and internal accumulators=0.
- Decode, with ALUOp=10 and {f7,f3}:
  - 0000000_111 AND; 0000000_110 OR; 0000000_100 XOR; 0000000_001 SLL; 0000000_101 SRL.
  - 0000000_000 ADD; 0100000_000 SUB; 0000000_010 SLT; 0000000_011 SLTU.
  - 0000001_000 MUL (low XLEN); 0000001_001 MULH (signed high XLEN).
  - 0000001_100 DIV; 0000001_101 DIVU; 0000001_110 REM; 0000001_111 REMU.
- Decode, with ALUOp=11: f3=000 ADDI; f3=101 with f7=0100000 SRAI, shamt=rs2_i[$clog2(XLEN)-1:0].
- ALUOp=00: ADD. Any other encoding: result 0, illegal_o=1.
- Single-cycle ops: start_i in cycle N gives result_o/valid_o in cycle N+1; busy_o stays 0.
- Shift amounts use the low $clog2(XLEN) bits. Add/sub wrap modulo 2^XLEN.
- FSM IDLE -> MUL or DIV -> DONE -> IDLE:
  - IDLE: start_i with a MUL-class op -> MUL; with a DIV-class op -> DIV; busy_o rises in cycle N+1.
  - MUL: radix-2 shift-add over operand magnitudes, one bit per cycle, XLEN cycles; sign fixed at the end for MULH.
  - DIV: restoring division on magnitudes, XLEN cycles; quotient/remainder signs corrected at the end.
  - DONE: result_o loaded, valid_o=1 for one cycle, busy_o=0 -> IDLE.
  - Total latency start -> valid_o = XLEN+2 cycles. A new start_i is accepted in the DONE cycle (back-to-back).
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1. Still takes full latency; not illegal.
- Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV = rs1, REM = 0.
- start_i while busy_o=1: ignored, no side effects.
- flush_i=1: next state IDLE; busy_o=0 and valid_o=0 next cycle; in-flight result discarded. A start_i in the same cycle is dropped.
- rst_i asserted mid-operation: immediate return to reset values; no valid_o.
- Operands are latched at start; rs1_i/rs2_i may change during busy.

Optional Feature:
- Macro ALU_MD_DIV_EN.
- Defined: the divider datapath and DIV state are built; DIV/DIVU/REM/REMU behave as above.
- Undefined: no divider logic is built. DIV-class encodings complete single-cycle with result 0 and illegal_o=1; the FSM never enters DIV.

Test Plan:
- XLEN=32, ALUOp=10, f=0000000_000, rs1=5, rs2=7, start -> next cycle valid_o=1, result=12, busy_o=0.
- ALUOp=11, f=0100000_101, rs1=0x80000000, rs2=4 -> result=0xF8000000 after 1 cycle.
- MUL rs1=0xFFFFFFFF (-1), rs2=3 -> busy_o high 33 cycles, valid at cycle 34, result=0xFFFFFFFD. MULH on the same operands -> 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> -3 (0xFFFFFFFD); REM -> 0xFFFFFFFF. DIVU by 0 -> 0xFFFFFFFF. REM 0x80000000 by -1 -> 0. DIV 0x80000000 by -1 -> 0x80000000.
- Start DIV, assert flush_i at iteration 10 -> busy_o=0 next cycle, no valid_o. Repeat with rst_i instead -> all outputs 0 immediately.
- Illegal f=1111111_000 -> valid_o=1, illegal_o=1, result=0. With ALU_MD_DIV_EN undefined, DIV -> illegal_o=1 in 1 cycle.
